// File: rtl/add_arbiter.sv
// add_arbiter: two requesters share one BITS-wide signed adder.
// Round-robin grant, one registered response port carrying sum,
// signed-overflow flag and requester ID.
// Optional build macro ADD_ARBITER_SAT_EN: on overflow the sum saturates
// to the most positive / most negative value instead of wrapping.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Requesters hold valid and operands until accepted. The
// response holds o_rsp_valid and its payload until i_rsp_ready is seen.
module add_arbiter #(
  parameter int BITS = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_req0_valid,
  input  logic [BITS-1:0] i_req0_a,
  input  logic [BITS-1:0] i_req0_b,
  output logic            o_req0_ready,
  input  logic            i_req1_valid,
  input  logic [BITS-1:0] i_req1_a,
  input  logic [BITS-1:0] i_req1_b,
  output logic            o_req1_ready,
  output logic            o_rsp_valid,
  output logic            o_rsp_id,
  output logic [BITS-1:0] o_rsp_sum,
  output logic            o_rsp_ovf,
  input  logic            i_rsp_ready,
  output logic            o_busy,
  output logic [1:0]      o_dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            last_grant_q, last_grant_d;
  logic [BITS-1:0] a_q, a_d;
  logic [BITS-1:0] b_q, b_d;
  logic            id_q, id_d;
  logic [BITS-1:0] rsp_sum_q, rsp_sum_d;
  logic            rsp_ovf_q, rsp_ovf_d;
  logic            rsp_id_q, rsp_id_d;

  logic            grant0;
  logic            grant1;
  logic [BITS-1:0] sum_raw;
  logic            sum_ovf;
  logic [BITS-1:0] sum_res;

  // Round-robin grant: a lone valid wins; on a tie the requester that was
  // not served last wins. A low valid never receives a grant.
  always_comb begin
    grant0 = i_req0_valid & (~i_req1_valid | last_grant_q);
    grant1 = i_req1_valid & (~i_req0_valid | ~last_grant_q);
  end

  // Shared adder with signed overflow detection and optional saturation.
  always_comb begin
    sum_raw = a_q + b_q;
    sum_ovf = (a_q[BITS-1] == b_q[BITS-1]) & (sum_raw[BITS-1] != a_q[BITS-1]);
    sum_res = sum_raw;
`ifdef ADD_ARBITER_SAT_EN
    if (sum_ovf) begin
      sum_res = a_q[BITS-1] ? {1'b1, {(BITS-1){1'b0}}} : {1'b0, {(BITS-1){1'b1}}};
    end
`else
    sum_res = sum_raw;
`endif
  end

  // Next-state and datapath capture for the IDLE -> CALC -> RESP sequence.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    a_d          = a_q;
    b_d          = b_q;
    id_d         = id_q;
    rsp_sum_d    = rsp_sum_q;
    rsp_ovf_d    = rsp_ovf_q;
    rsp_id_d     = rsp_id_q;
    case (state_q)
      IDLE: begin
        if (grant0 | grant1) begin
          a_d          = grant1 ? i_req1_a : i_req0_a;
          b_d          = grant1 ? i_req1_b : i_req0_b;
          id_d         = grant1;
          last_grant_d = grant1;
          state_d      = CALC;
        end
      end
      CALC: begin
        rsp_sum_d = sum_res;
        rsp_ovf_d = sum_ovf;
        rsp_id_d  = id_q;
        state_d   = RESP;
      end
      RESP: begin
        if (i_rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and payload registers; reset discards any operation in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      rsp_sum_q    <= '0;
      rsp_ovf_q    <= 1'b0;
      rsp_id_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      a_q          <= a_d;
      b_q          <= b_d;
      id_q         <= id_d;
      rsp_sum_q    <= rsp_sum_d;
      rsp_ovf_q    <= rsp_ovf_d;
      rsp_id_q     <= rsp_id_d;
    end
  end

  // Outputs; readies and response valid are masked while reset is high.
  always_comb begin
    o_req0_ready = (state_q == IDLE) & grant0 & ~i_rst;
    o_req1_ready = (state_q == IDLE) & grant1 & ~i_rst;
    o_rsp_valid  = (state_q == RESP) & ~i_rst;
    o_rsp_id     = rsp_id_q;
    o_rsp_sum    = rsp_sum_q;
    o_rsp_ovf    = rsp_ovf_q;
    o_busy       = (state_q != IDLE);
    o_dbg_state  = state_q;
  end

endmodule
